// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO store monitor.
// Contents: channel address stride, overflow counter width, trace entry layout.
// The trace entry layout fixes the address/data widths that the FIFO stores;
// the top-level ADDR_W/DATA_W parameters default to these values.
package mmio_pkg;

  localparam int unsigned CH_STRIDE  = 4;
  localparam int unsigned OVF_W      = 16;
  localparam int unsigned TRC_ADDR_W = 16;
  localparam int unsigned TRC_DATA_W = 32;

  typedef struct packed {
    logic [TRC_ADDR_W-1:0] addr;
    logic [TRC_DATA_W-1:0] data;
  } trc_entry_t;

endpackage

// File: rtl/store_trace_fifo.sv
// First-word-fall-through FIFO of trace entries with registered storage.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_entry write request and entry
//   pop              read request (ignored when empty)
//   head             entry at the read pointer (valid while !empty)
//   full, empty      derived from the level counter
//   level            current entry count
//   drop             push refused this cycle (full and no simultaneous pop)
module store_trace_fifo
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  trc_entry_t       push_entry,
  input  logic             pop,
  output trc_entry_t       head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             drop
);

  trc_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [LVL_W-1:0] lvl_q;
  logic             pop_acc;
  logic             push_acc;

  assign full  = (lvl_q == LVL_W'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;
  assign head  = mem[rptr];

  // A pop frees the slot in the same cycle, so a push into a full FIFO
  // alongside a pop is accepted rather than dropped.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign drop     = push && !push_acc;

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_acc) wptr <= wptr + PTR_W'(1);
      if (pop_acc)  rptr <= rptr + PTR_W'(1);
      lvl_q <= lvl_q + LVL_W'(push_acc) - LVL_W'(pop_acc);
    end
  end

endmodule

// File: rtl/mmio_store_monitor.sv
// Snoops the core data-store bus, latches stores to N_CH memory-mapped
// output channels and queues store events in a back-pressured trace FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   WE, address,    core store strobe, byte address, data
//   writeData
//   ch_data         channel registers, channel i at [i*DATA_W +: DATA_W]
//   ch_upd          one-cycle pulse per channel written
//   trc_valid/ready trace stream handshake; trc_addr/trc_data = head entry
//   fifo_level      current trace entry count
//   ovf_cnt         saturating count of events dropped on a full FIFO
// Build option: TRACE_ALL_EN traces every WE cycle regardless of address;
// otherwise only channel hits are traced. Channel decode is the same in both.
module mmio_store_monitor
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W     = TRC_ADDR_W,
  parameter int unsigned DATA_W     = TRC_DATA_W,
  parameter int unsigned N_CH       = 4,
  parameter logic [ADDR_W-1:0] CH_BASE = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WE,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      writeData,
  output logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_upd,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [ADDR_W-1:0]      trc_addr,
  output logic [DATA_W-1:0]      trc_data,
  output logic [LVL_W-1:0]       fifo_level,
  output logic [OVF_W-1:0]       ovf_cnt
);

  logic [DATA_W-1:0] ch_q [N_CH];
  logic [N_CH-1:0]   hit_vec;
  logic [N_CH-1:0]   upd_q;
  logic [OVF_W-1:0]  ovf_q;
  logic              evt;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  trc_entry_t        push_entry;
  trc_entry_t        head;

  // Exact-match against each channel address covers alignment and range.
  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      hit_vec[i] = WE && (address == CH_BASE + ADDR_W'(CH_STRIDE * i));
    end
  end

`ifdef TRACE_ALL_EN
  assign evt = WE;
`else
  assign evt = |hit_vec;
`endif

  assign push_entry.addr = address;
  assign push_entry.data = writeData;

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        ch_q[i] <= '0;
      end
    end else begin
      upd_q <= hit_vec;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (hit_vec[i]) ch_q[i] <= writeData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (drop && (ovf_q != '1)) begin
      ovf_q <= ovf_q + OVF_W'(1);
    end
  end

  store_trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (evt),
    .push_entry (push_entry),
    .pop        (trc_ready),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level),
    .drop       (drop)
  );

  always_comb begin
    ch_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_data[i*DATA_W +: DATA_W] = ch_q[i];
    end
  end

  assign ch_upd    = upd_q;
  assign ovf_cnt   = ovf_q;
  assign trc_valid = !fifo_empty;
  assign trc_addr  = head.addr;
  assign trc_data  = head.data;

endmodule

// File: tb/tb_mmio_store_monitor.sv
// Randomized self-checking bench for mmio_store_monitor with a queue-based
// reference model of the channel registers, trace FIFO and overflow counter.
module tb_mmio_store_monitor;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 WE = 1'b0;
  logic [15:0]          address = '0;
  logic [31:0]          writeData = '0;
  logic [N_CH*32-1:0]   ch_data;
  logic [N_CH-1:0]      ch_upd;
  logic                 trc_valid;
  logic                 trc_ready = 1'b0;
  logic [15:0]          trc_addr;
  logic [31:0]          trc_data;
  logic [3:0]           fifo_level;
  logic [15:0]          ovf_cnt;

  mmio_store_monitor #(
    .ADDR_W     (16),
    .DATA_W     (32),
    .N_CH       (N_CH),
    .CH_BASE    (16'hFF00),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .WE         (WE),
    .address    (address),
    .writeData  (writeData),
    .ch_data    (ch_data),
    .ch_upd     (ch_upd),
    .trc_valid  (trc_valid),
    .trc_ready  (trc_ready),
    .trc_addr   (trc_addr),
    .trc_data   (trc_data),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [47:0]     m_q[$];
  logic [31:0]     m_ch [N_CH];
  logic [N_CH-1:0] m_upd;
  int unsigned     m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < N_CH; i++) m_ch[i] = '0;
    m_upd = '0;
    m_ovf = 0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [15:0] a,
                            input logic [31:0] d, input logic rdy);
    bit hit, ev, was_full, pop;
    int unsigned idx;
    if (r) begin
      model_clear();
      return;
    end
    hit = w && (a % 4 == 0) && (a >= 16'hFF00) && (a < 16'hFF00 + 4 * N_CH);
    idx = hit ? (a - 16'hFF00) / 4 : 0;
    m_upd = '0;
    if (hit) begin
      m_ch[idx]  = d;
      m_upd[idx] = 1'b1;
    end
`ifdef TRACE_ALL_EN
    ev = w;
`else
    ev = hit;
`endif
    was_full = (m_q.size() == DEPTH);
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      if (!was_full || pop) m_q.push_back({a, d});
      else if (m_ovf < 16'hFFFF) m_ovf++;
    end
  endtask

  task automatic compare_all();
    logic [47:0] hd;
    check("ch_upd", 64'(ch_upd), 64'(m_upd));
    for (int i = 0; i < N_CH; i++) check($sformatf("ch_data[%0d]", i), 64'(ch_data[i*32 +: 32]), 64'(m_ch[i]));
    check("trc_valid", 64'(trc_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      hd = m_q[0];
      check("trc_addr", 64'(trc_addr), 64'(hd[47:32]));
      check("trc_data", 64'(trc_data), 64'(hd[31:0]));
    end
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
  endtask

  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic rdy);
    @(negedge clk);
    rst = r; WE = w; address = a; writeData = d; trc_ready = rdy;
    model_step(r, w, a, d, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] a;
    int unsigned pct;
    model_clear();

    // 1: reset, then a single channel-1 store
    step(1, 0, 16'h0, 32'h0, 0);
    step(1, 0, 16'h0, 32'h0, 0);
    check("t1_rst_valid", 64'(trc_valid), 64'd0);
    step(0, 1, 16'hFF04, 32'hDEAD_BEEF, 0);
    check("t1_upd", 64'(ch_upd), 64'b0010);
    check("t1_ch1", 64'(ch_data[63:32]), 64'hDEAD_BEEF);
    check("t1_trc", 64'({trc_valid, trc_addr, trc_data}), {15'd0, 1'b1, 16'hFF04, 32'hDEAD_BEEF});
    step(0, 0, 16'h0, 32'h0, 1);
    check("t1_upd_clr", 64'(ch_upd), 64'd0);

    // 2: misaligned and out-of-range stores
    step(0, 1, 16'hFF06, 32'h1111_1111, 0);
    step(0, 1, 16'hFF10, 32'h2222_2222, 0);
    step(0, 0, 16'h0, 32'h0, 1);
    step(0, 0, 16'h0, 32'h0, 1);
    step(0, 0, 16'h0, 32'h0, 1);

    // 3: ten hits with back-pressure, then drain
    for (int i = 0; i < 10; i++) step(0, 1, 16'hFF00 + 16'(4 * (i % 4)), 32'hA000_0000 + 32'(i), 0);
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_ovf", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 9; i++) step(0, 0, 16'h0, 32'h0, 1);
    check("t3_drained", 64'(trc_valid), 64'd0);

    // 4: full FIFO, store and pop together
    for (int i = 0; i < 8; i++) step(0, 1, 16'hFF08, 32'hB000_0000 + 32'(i), 0);
    step(0, 1, 16'hFF0C, 32'hC0FF_EE00, 1);
    check("t4_level", 64'(fifo_level), 64'd8);

    // 5: reset with queued entries and a concurrent store
    step(1, 0, 16'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 16'hFF00, 32'hD000_0000 + 32'(i), 0);
    step(1, 1, 16'hFF04, 32'h5555_5555, 0);
    check("t5_level", 64'(fifo_level), 64'd0);
    check("t5_ch1", 64'(ch_data[63:32]), 64'd0);

    // 6: overflow counter saturation
    for (int i = 0; i < 8; i++) step(0, 1, 16'hFF00, 32'hE000_0000 + 32'(i), 0);
    @(negedge clk);
    force dut.ovf_q = 16'hFFFE;
    #1;
    release dut.ovf_q;
    m_ovf = 16'hFFFE;
    for (int i = 0; i < 3; i++) step(0, 1, 16'hFF04, 32'hF000_0000 + 32'(i), 0);
    check("t6_sat", 64'(ovf_cnt), 64'hFFFF);

    // Random traffic with varying back-pressure
    step(1, 0, 16'h0, 32'h0, 0);
    for (int i = 0; i < 600; i++) begin
      pct = (i / 100) % 2 == 0 ? 30 : 80;
      case ($urandom_range(0, 4))
        0, 1: a = 16'hFF00 + 16'(4 * $urandom_range(0, N_CH - 1));
        2:    a = 16'hFF00 + 16'(4 * $urandom_range(0, N_CH - 1)) + 16'($urandom_range(1, 3));
        3:    a = 16'hFF00 + 16'(4 * N_CH) + 16'($urandom_range(0, 63));
        default: a = 16'($urandom);
      endcase
      step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 99) < pct);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
